// File: rtl/pico_wb_master_bridge.sv
// -----------------------------------------------------------------------------
// pico_wb_master_bridge
//
// Bridges the picorv32 native memory interface onto a Wishbone B4 pipelined
// master port. The bridge claims one address window and runs one single-beat
// WB cycle for each core request that falls inside it. A bus error or a
// no-response timeout still completes the core access, and it also latches
// a sticky error record.
//
// Ports
//   clk            system clock
//   i_resetn       asynchronous active-low reset
//   i_mem_*        picorv32 request (valid/addr/wdata/wstrb; wstrb==0 is a read)
//   o_sel          combinational window hit, for the core-side ready/rdata mux
//   o_mem_ready    one-cycle completion pulse to the core
//   o_mem_rdata    read data, meaningful only while o_mem_ready is high
//   o_wb_m2s_*     Wishbone master outputs (cyc/stb/we/addr/data/sel)
//   i_wb_s2m_*     Wishbone slave responses (data/ack/stall/err)
//   i_err_clr      synchronous clear of the sticky error record
//   o_err_flag     sticky: an error or timeout has been seen
//   o_err_timeout  type of the most recent recorded error (1 = timeout)
//   o_err_addr     address of the first error since the last clear
// -----------------------------------------------------------------------------
module pico_wb_master_bridge #(
   parameter logic [31:0] ADDR_BASE      = 32'h8000_0000,
   parameter logic [31:0] ADDR_MASK      = 32'hFFFF_F000,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        i_resetn,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic [3:0]  i_mem_wstrb,
   output logic        o_sel,
   output logic        o_mem_ready,
   output logic [31:0] o_mem_rdata,
   output logic        o_wb_m2s_cyc,
   output logic        o_wb_m2s_stb,
   output logic        o_wb_m2s_we,
   output logic [31:0] o_wb_m2s_addr,
   output logic [31:0] o_wb_m2s_data,
   output logic [3:0]  o_wb_m2s_sel,
   input  logic [31:0] i_wb_s2m_data,
   input  logic        i_wb_s2m_ack,
   input  logic        i_wb_s2m_stall,
   input  logic        i_wb_s2m_err,
   input  logic        i_err_clr,
   output logic        o_err_flag,
   output logic        o_err_timeout,
   output logic [31:0] o_err_addr
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [3:0]        sel_q, sel_d;
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_flag_q, err_flag_d;
   logic              err_timeout_q, err_timeout_d;
   logic [31:0]       err_addr_q, err_addr_d;

   logic              fin_resp;
   logic              fin_tmo;
   logic              err_event;
   logic              expired;

   assign o_sel = i_mem_valid && ((i_mem_addr & ADDR_MASK) == ADDR_BASE);

   // The last counted cycle of the transaction; a response in this same
   // cycle still wins over the timeout.
   assign expired = TO_EN && (cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      cyc_d         = cyc_q;
      stb_d         = stb_q;
      we_d          = we_q;
      addr_d        = addr_q;
      data_d        = data_q;
      sel_d         = sel_q;
      ready_d       = 1'b0;
      rdata_d       = 32'h0;
      cnt_d         = cnt_q;
      err_flag_d    = err_flag_q;
      err_timeout_d = err_timeout_q;
      err_addr_d    = err_addr_q;
      fin_resp      = 1'b0;
      fin_tmo       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (o_sel) begin
               state_d = ST_REQ;
               addr_d  = i_mem_addr;
               data_d  = i_mem_wdata;
               sel_d   = i_mem_wstrb;
               we_d    = |i_mem_wstrb;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A response only counts once the strobe has been accepted.
            if (!i_wb_s2m_stall && (i_wb_s2m_ack || i_wb_s2m_err)) begin
               fin_resp = 1'b1;
            end else if (expired) begin
               fin_tmo = 1'b1;
            end else if (!i_wb_s2m_stall) begin
               state_d = ST_WAIT;
               stb_d   = 1'b0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (i_wb_s2m_ack || i_wb_s2m_err) begin
               fin_resp = 1'b1;
            end else if (expired) begin
               fin_tmo = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Completion is shared by the response and timeout paths. Err beats
      // ack when both arrive together; writes always return zero data.
      if (fin_resp || fin_tmo) begin
         state_d = ST_DONE;
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         ready_d = 1'b1;
         if (we_q) begin
            rdata_d = 32'h0;
         end else if (fin_tmo || i_wb_s2m_err) begin
            rdata_d = ERR_RDATA;
         end else begin
            rdata_d = i_wb_s2m_data;
         end
      end

      // A new error outranks a same-cycle clear. The clear reopens the
      // record, so the new error's address is captured as the first one.
      err_event = (fin_resp && i_wb_s2m_err) || fin_tmo;
      if (err_event) begin
         err_flag_d    = 1'b1;
         err_timeout_d = fin_tmo;
         if (!err_flag_q || i_err_clr) begin
            err_addr_d = addr_q;
         end
      end else if (i_err_clr) begin
         err_flag_d    = 1'b0;
         err_timeout_d = 1'b0;
         err_addr_d    = 32'h0;
      end
   end

   always_ff @(posedge clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q       <= ST_IDLE;
         cyc_q         <= 1'b0;
         stb_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= 32'h0;
         data_q        <= 32'h0;
         sel_q         <= 4'h0;
         ready_q       <= 1'b0;
         rdata_q       <= 32'h0;
         cnt_q         <= '0;
         err_flag_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         err_addr_q    <= 32'h0;
      end else begin
         state_q       <= state_d;
         cyc_q         <= cyc_d;
         stb_q         <= stb_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         sel_q         <= sel_d;
         ready_q       <= ready_d;
         rdata_q       <= rdata_d;
         cnt_q         <= cnt_d;
         err_flag_q    <= err_flag_d;
         err_timeout_q <= err_timeout_d;
         err_addr_q    <= err_addr_d;
      end
   end

   assign o_mem_ready   = ready_q;
   assign o_mem_rdata   = rdata_q;
   assign o_wb_m2s_cyc  = cyc_q;
   assign o_wb_m2s_stb  = stb_q;
   assign o_wb_m2s_we   = we_q;
   assign o_wb_m2s_addr = addr_q;
   assign o_wb_m2s_data = data_q;
   assign o_wb_m2s_sel  = sel_q;
   assign o_err_flag    = err_flag_q;
   assign o_err_timeout = err_timeout_q;
   assign o_err_addr    = err_addr_q;

endmodule
